// File: rtl/exec_storage_unit.sv
// Execution and storage core: 8x8 register file, 8-bit ALU with zero flag,
// and a 256-byte data memory behind a multi-cycle busy-wait handshake.
module exec_storage_unit #(
    parameter int unsigned MEM_LATENCY = 5,
    parameter int unsigned MEM_DEPTH   = 256
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] rf_wdata,
    input  logic [2:0] rf_waddr,
    input  logic [2:0] rf_raddr1,
    input  logic [2:0] rf_raddr2,
    input  logic       rf_we,
    output logic [7:0] rf_rdata1,
    output logic [7:0] rf_rdata2,
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic [2:0] alu_op,
    output logic [7:0] alu_result,
    output logic       alu_zero,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [7:0] mem_addr,
    input  logic [7:0] mem_wdata,
    output logic [7:0] mem_rdata,
    output logic       mem_busywait
);

    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mem_state_e;

    mem_state_e       r_state;
    mem_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_regs [8];
    logic [7:0]       r_mem [MEM_DEPTH];
    logic [7:0]       r_rdata;
    logic             w_req;
    logic             w_busy;
    logic             w_complete;
    logic [7:0]       w_alu;
    logic [7:0]       w_shift;
    logic [15:0]      w_rol_full;
    logic [15:0]      w_ror_full;

    assign w_req      = mem_read | mem_write;
    // Access completes on the edge where the counter would reach MEM_LATENCY.
    assign w_complete = (r_state == StBusy) && w_req &&
                        ((32'(r_cnt) + 32'd1) >= MEM_LATENCY);

    // Memory FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Memory FSM next-state logic; a dropped request aborts a busy access.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_req) w_state_next = StBusy;
            StBusy: begin
                if (!w_req) begin
                    w_state_next = StIdle;
                end else if (w_complete) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = w_req ? StBusy : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Memory FSM outputs: busy while a request waits in idle or an access runs.
    always_comb begin
        w_busy = 1'b0;
        unique case (r_state)
            StIdle:  w_busy = w_req;
            StBusy:  w_busy = 1'b1;
            StDone:  w_busy = 1'b0;
            default: w_busy = 1'b0;
        endcase
    end

    // Latency counter: starts at 1 on entry to busy, counts up while busy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (w_state_next == StBusy && r_state != StBusy) begin
            r_cnt <= CNT_W'(1);
        end else if (r_state == StBusy) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Data memory and read-data register; write wins when both are requested.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else if (w_complete) begin
            if (mem_write) begin
                r_mem[mem_addr] <= mem_wdata;
            end else begin
                r_rdata <= r_mem[mem_addr];
            end
        end
    end

    // Register file write; held off while busy so a load writes back once.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (rf_we && !w_busy) begin
            r_regs[rf_waddr] <= rf_wdata;
        end
    end

    assign rf_rdata1    = r_regs[rf_raddr1];
    assign rf_rdata2    = r_regs[rf_raddr2];
    assign mem_rdata    = r_rdata;
    assign mem_busywait = w_busy;

    // Rotates via a doubled word so the wrapped bits fall into the kept byte.
    assign w_rol_full = {alu_a, alu_a} << alu_b[2:0];
    assign w_ror_full = {alu_a, alu_a} >> alu_b[2:0];

    // Shift/rotate unit: type in alu_b[7:5], amount in alu_b[2:0].
    always_comb begin
        w_shift = '0;
        unique case (alu_b[7:5])
            3'b000, 3'b010: w_shift = alu_a << alu_b[2:0];
            3'b001:         w_shift = alu_a >> alu_b[2:0];
            3'b011:         w_shift = $signed(alu_a) >>> alu_b[2:0];
            3'b100:         w_shift = w_rol_full[15:8];
            3'b101:         w_shift = w_ror_full[7:0];
            default:        w_shift = '0;
        endcase
    end

    // ALU operation select; compare is an add of the pre-negated operand.
    always_comb begin
        w_alu = '0;
        unique case (alu_op)
            3'b000:         w_alu = alu_b;
            3'b001, 3'b111: w_alu = alu_a + alu_b;
            3'b010:         w_alu = alu_a & alu_b;
            3'b011:         w_alu = alu_a | alu_b;
            3'b100:         w_alu = w_shift;
            default:        w_alu = '0;
        endcase
    end

    assign alu_result = w_alu;
    assign alu_zero   = (w_alu == 8'h00);

endmodule

// File: tb/tb_exec_storage_unit.sv
// Bench for exec_storage_unit: behavioural model checked every cycle plus
// directed vectors with literal expectations.
module tb_exec_storage_unit;

    localparam int LAT = 5;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] rf_wdata;
    logic [2:0] rf_waddr, rf_raddr1, rf_raddr2;
    logic       rf_we;
    logic [7:0] rf_rdata1, rf_rdata2;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic       mem_read, mem_write, mem_busywait;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    // Write-back mux as the CPU would build it: memory data or a direct value.
    logic       use_mem;
    logic [7:0] wdata_drv;
    assign rf_wdata = use_mem ? mem_rdata : wdata_drv;

    exec_storage_unit #(.MEM_LATENCY(LAT), .MEM_DEPTH(256)) dut (
        .CLK(CLK), .RESET(RESET),
        .rf_wdata(rf_wdata), .rf_waddr(rf_waddr), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_we(rf_we), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_busywait(mem_busywait)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU reference: shifts applied one bit at a time, n times.
    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        logic [7:0] v;
        logic [2:0] t;
        case (op)
            3'd0: return b;
            3'd1: return 8'((int'(a) + int'(b)) % 256);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd7: return 8'((int'(a) + int'(b)) % 256);
            3'd4: begin
                v = a;
                t = b[7:5];
                for (int i = 0; i < int'(b[2:0]); i++) begin
                    case (t)
                        3'd0, 3'd2: v = {v[6:0], 1'b0};
                        3'd1:       v = {1'b0, v[7:1]};
                        3'd3:       v = {v[7], v[7:1]};
                        3'd4:       v = {v[6:0], v[7]};
                        3'd5:       v = {v[0], v[7:1]};
                        default:    v = 8'h00;
                    endcase
                end
                if (t >= 3'd6) v = 8'h00;
                return v;
            end
            default: return 8'h00;
        endcase
    endfunction

    // Model state: contents, last read value, and cycles spent on the current access.
    logic [7:0] m_regs [8];
    logic [7:0] m_mem [256];
    logic [7:0] m_rdata;
    int         m_cnt  = 0;
    bit         m_done = 1'b0;
    bit         m_valid = 1'b0;

    // Compare process: check outputs mid-cycle, then advance the model to the next edge.
    always @(negedge CLK) begin
        logic req;
        logic exp_busy;
        logic [7:0] exp_alu;
        req      = mem_read | mem_write;
        exp_busy = !m_done && (m_cnt > 0 || req);
        exp_alu  = alu_model(alu_a, alu_b, alu_op);
        if (m_valid) begin
            check("cmp rf_rdata1", rf_rdata1, m_regs[rf_raddr1]);
            check("cmp rf_rdata2", rf_rdata2, m_regs[rf_raddr2]);
            check("cmp alu_result", alu_result, exp_alu);
            check("cmp alu_zero", {7'b0, alu_zero}, {7'b0, exp_alu == 8'h00});
            check("cmp mem_busywait", {7'b0, mem_busywait}, {7'b0, exp_busy});
            check("cmp mem_rdata", mem_rdata, m_rdata);
        end
        if (RESET) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            m_rdata = 8'h00;
            m_cnt   = 0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (rf_we && !exp_busy) m_regs[rf_waddr] = rf_wdata;
            if (m_done) begin
                m_done = 1'b0;
                m_cnt  = req ? 1 : 0;
            end else if (exp_busy) begin
                if (m_cnt > 0 && !req) begin
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == LAT) begin
                        if (mem_write) m_mem[mem_addr] = mem_wdata;
                        else m_rdata = m_mem[mem_addr];
                        m_cnt  = 0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Run one access; returns in the first non-busy cycle with the request dropped.
    task automatic mem_access(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                              input bit load, input logic [2:0] dst, output int cyc);
        mem_write = wr;
        mem_read  = !wr;
        mem_addr  = addr;
        mem_wdata = data;
        if (load) begin
            rf_we     = 1'b1;
            rf_waddr  = dst;
            wdata_drv = 8'h77;
        end
        #2;
        cyc = 0;
        while (mem_busywait && cyc < 20) begin
            cyc++;
            step();
            #2;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (load) use_mem = 1'b1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] r;
    } vec_t;

    vec_t vecs [14] = '{
        '{8'hF0, 8'h20, 3'd1, 8'h10}, '{8'h07, 8'hF9, 3'd7, 8'h00},
        '{8'hCC, 8'hAA, 3'd2, 8'h88}, '{8'hCC, 8'hAA, 3'd3, 8'hEE},
        '{8'h96, 8'h22, 3'd4, 8'h25}, '{8'h96, 8'h62, 3'd4, 8'hE5},
        '{8'h96, 8'h81, 3'd4, 8'h2D}, '{8'h96, 8'hA1, 3'd4, 8'h4B},
        '{8'h96, 8'h41, 3'd4, 8'h2C}, '{8'h96, 8'h18, 3'd4, 8'h96},
        '{8'h96, 8'hC3, 3'd4, 8'h00}, '{8'h96, 8'h03, 3'd0, 8'h03},
        '{8'h55, 8'hAA, 3'd5, 8'h00}, '{8'h96, 8'h03, 3'd4, 8'hB0}
    };

    initial begin
        int cyc;
        RESET = 1'b1; rf_we = 1'b0; rf_waddr = '0; rf_raddr1 = '0; rf_raddr2 = '0;
        alu_a = '0; alu_b = '0; alu_op = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = '0; mem_wdata = '0; use_mem = 1'b0; wdata_drv = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rf_raddr1 = 3'(i);
            rf_raddr2 = 3'(7 - i);
            #2;
            check("reset reg", rf_rdata1, 8'h00);
            step();
        end

        rf_we = 1'b1; rf_waddr = 3'd3; wdata_drv = 8'h5A; rf_raddr1 = 3'd3;
        #2;
        check("read during write old", rf_rdata1, 8'h00);
        step();
        rf_we = 1'b0;
        #2;
        check("r3 written", rf_rdata1, 8'h5A);
        step();

        foreach (vecs[i]) begin
            alu_a = vecs[i].a; alu_b = vecs[i].b; alu_op = vecs[i].op;
            #2;
            check("alu result", alu_result, vecs[i].r);
            check("alu zero", {7'b0, alu_zero}, {7'b0, vecs[i].r == 8'h00});
            step();
        end

        mem_access(1'b1, 8'h10, 8'h3C, 1'b0, 3'd0, cyc);
        check("write busy cycles", 8'(cyc), 8'd5);
        step();

        rf_raddr2 = 3'd5;
        mem_access(1'b0, 8'h10, 8'h00, 1'b1, 3'd5, cyc);
        check("read busy cycles", 8'(cyc), 8'd5);
        check("read data in done", mem_rdata, 8'h3C);
        check("load not yet stored", rf_rdata2, 8'h00);
        step();
        rf_we = 1'b0; use_mem = 1'b0;
        #2;
        check("load written back", rf_rdata2, 8'h3C);
        step();

        mem_write = 1'b1; mem_addr = 8'h30; mem_wdata = 8'h55;
        step();
        step();
        mem_write = 1'b0;
        #2;
        check("busy after drop", {7'b0, mem_busywait}, 8'h01);
        step();
        #2;
        check("idle after abort", {7'b0, mem_busywait}, 8'h00);
        check("rdata kept after abort", mem_rdata, 8'h3C);
        step();
        mem_access(1'b0, 8'h30, 8'h00, 1'b0, 3'd0, cyc);
        check("aborted write absent", mem_rdata, 8'h00);
        step();

        mem_access(1'b1, 8'h11, 8'hC7, 1'b0, 3'd0, cyc);
        step();
        mem_write = 1'b1; mem_addr = 8'h11; mem_wdata = 8'h99; rf_raddr1 = 3'd3;
        step();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0; mem_write = 1'b0;
        #2;
        check("busy cleared by reset", {7'b0, mem_busywait}, 8'h00);
        check("r3 cleared", rf_rdata1, 8'h00);
        check("r5 cleared", rf_rdata2, 8'h00);
        step();
        mem_access(1'b0, 8'h11, 8'h00, 1'b0, 3'd0, cyc);
        check("reset read busy cycles", 8'(cyc), 8'd5);
        check("target byte cleared", mem_rdata, 8'h00);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exec_storage_unit.md
Name: exec_storage_unit

Overview:
- Execution and storage core of the 8-bit single-cycle CPU. It bundles three functions:
  - an 8x8-bit register file (two combinational read ports, one synchronous write port);
  - a combinational 8-bit ALU with zero flag;
  - a 256-byte data memory with a multi-cycle busy-wait handshake.
- The surrounding CPU does the following outside this block:
  - supplies ALU operand B (register, negated register or immediate);
  - feeds the ALU result back as the memory address;
  - selects ALU result or memory read data as the register write-back value;
  - stalls PC while mem_busywait is high.

Parameters:
- MEM_LATENCY, 5, clock cycles from request acceptance to access completion (must be >= 1).
- MEM_DEPTH, 256, data memory bytes, addressed by the full 8-bit address.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, synchronous, active-high.
- rf_wdata  in  8  register write data.
- rf_waddr  in  3  register write address.
- rf_raddr1  in  3  read port 1 address.
- rf_raddr2  in  3  read port 2 address.
- rf_we  in  1  register write enable.
- rf_rdata1  out  8  register[rf_raddr1].
- rf_rdata2  out  8  register[rf_raddr2].
- alu_a  in  8  ALU operand A.
- alu_b  in  8  ALU operand B.
- alu_op  in  3  ALU operation select.
- alu_result  out  8  ALU result.
- alu_zero  out  1  high when alu_result == 0.
- mem_read  in  1  read request.
- mem_write  in  1  write request.
- mem_addr  in  8  byte address.
- mem_wdata  in  8  write data.
- mem_rdata  out  8  read data.
- mem_busywait  out  1  high while an access is in progress.

Behaviour:
- Reset: synchronous, active-high, priority over all other activity.
  - Clears all 8 registers and all memory bytes to 0x00.
  - Clears mem_rdata to 0x00 and returns the memory FSM to IDLE (mem_busywait = 0 after the edge).
  - An in-flight access is aborted with no write.
- Register file:
  - Reads are combinational, including register 0 (no hardwired zero).
  - Write occurs at the posedge when rf_we=1 and mem_busywait=0; the write is suppressed while busy so a load writes back exactly once.
  - Read-during-write returns the old value until the edge.
- ALU (purely combinational):
  - 000: forward, result = alu_b.
  - 001: add, alu_a + alu_b mod 256.
  - 010: alu_a AND alu_b.
  - 011: alu_a OR alu_b.
  - 100: shift/rotate of alu_a.
    - Type = alu_b[7:5], amount n = alu_b[2:0]; alu_b[4:3] are ignored; n = 0 leaves alu_a unchanged.
    - 000 sll and 010 sla: logical left, zero fill.
    - 001 srl: logical right, zero fill.
    - 011 sra: right, fill with alu_a[7].
    - 100 rol / 101 ror: rotate left / right by n.
    - Types 110 and 111 give 0x00.
  - 111: compare, alu_a + alu_b mod 256 (caller supplies the two's-complement negated operand).
  - 101, 110: result 0x00.
  - alu_zero = (alu_result == 0x00) for every op.
- Memory FSM states: IDLE, BUSY, DONE.
  - Request present = mem_read OR mem_write. When both are high, write has priority and no read occurs.
  - mem_busywait = 1 combinationally in IDLE with a request present and throughout BUSY; 0 in DONE and in IDLE with no request.
  - IDLE with request: at the posedge, go to BUSY and set the counter to 1.
  - BUSY: at each posedge the counter increments. At the posedge where the counter reaches MEM_LATENCY, the access is performed and the FSM goes to DONE.
    - Write: mem[mem_addr] = mem_wdata.
    - Read: mem_rdata = mem[mem_addr].
  - mem_addr and mem_wdata are sampled at the completion edge; the requester holds them stable.
  - DONE: one cycle, mem_busywait = 0, mem_rdata valid. At the next posedge return to IDLE; a request present then starts a new access on that edge (goes straight to BUSY).
  - Request dropped while in BUSY: abort, no write, return to IDLE; mem_rdata is unchanged.
  - mem_rdata holds the last read value until the next read completes or reset.
- Addresses wrap naturally; all 256 locations are valid.

Test Plan:
- Reset, then write 0x5A to r3 (rf_we=1, busy=0); next cycle rf_raddr1=3 -> 0x5A; every other register reads 0x00.
- ALU:
  - a=0xF0, b=0x20, op 001 -> 0x10, zero=0.
  - op 111 with a=0x07, b=0xF9 -> 0x00, zero=1.
  - op 010 with 0xCC/0xAA -> 0x88.
  - op 011 with 0xCC/0xAA -> 0xEE.
- Shifts on a=0x96:
  - b=0x22 (srl 2) -> 0x25.
  - b=0x62 (sra 2) -> 0xE5.
  - b=0x81 (rol 1) -> 0x2D.
  - b=0xA1 (ror 1) -> 0x4B.
- mem_write addr 0x10, data 0x3C held -> busywait high immediately and for 5 cycles, then low for 1 (DONE). A following read of 0x10 -> busywait 5 cycles, then mem_rdata=0x3C in DONE.
- Load write-back: rf_we=1 throughout a read -> register written only on the DONE-cycle edge; an earlier rf_wdata value is never stored.
- RESET asserted mid-write (cycle 3) -> busywait 0 after the edge, target byte reads back 0x00, all registers 0x00.
